// File: rtl/tdm_demux_1_to_4_if.sv
// Bus bundle for the 1:4 TDM demultiplexer: serial input side plus the four
// recovered channels and alignment status.
interface tdm_demux_1_to_4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] In;
    logic             InValid;
    logic             FrameSync;
    logic [WIDTH-1:0] Out0;
    logic [WIDTH-1:0] Out1;
    logic [WIDTH-1:0] Out2;
    logic [WIDTH-1:0] Out3;
    logic [1:0]       Sel;
    logic             Locked;
    logic             FrameValid;
    logic             SyncErr;

    modport master (
        output In, InValid, FrameSync,
        input  Out0, Out1, Out2, Out3, Sel, Locked, FrameValid, SyncErr
    );

    modport slave (
        input  In, InValid, FrameSync,
        output Out0, Out1, Out2, Out3, Sel, Locked, FrameValid, SyncErr
    );
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// Receive side of a 4-slot TDM link: hunts for the slot-0 marker, steers beats
// into per-slot shadows and publishes all four channels once per complete frame.
module tdm_demux_1_to_4 #(
    parameter int WIDTH = 1
) (
    input logic                Clk,
    input logic                ResetN,
    tdm_demux_1_to_4_if.slave  bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state_p0, state_d;
    logic [1:0]       sel_p0, sel_d;
    logic [WIDTH-1:0] sh0_p0, sh1_p0, sh2_p0;
    logic [WIDTH-1:0] sh0_d, sh1_d, sh2_d;
    logic [WIDTH-1:0] out0_p1, out1_p1, out2_p1, out3_p1;
    logic [WIDTH-1:0] out0_d, out1_d, out2_d, out3_d;
    logic             vld_p1, vld_d;
    logic             err_p1, err_d;

    always_comb begin
        state_d = state_p0;
        sel_d   = sel_p0;
        sh0_d   = sh0_p0;
        sh1_d   = sh1_p0;
        sh2_d   = sh2_p0;
        out0_d  = out0_p1;
        out1_d  = out1_p1;
        out2_d  = out2_p1;
        out3_d  = out3_p1;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        if (bus.InValid) begin
            unique case (state_p0)
                HUNT: begin
                    if (bus.FrameSync) begin
                        sh0_d   = bus.In;
                        sel_d   = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.FrameSync) begin
                        // A marker always restarts the frame; mid-frame it also flags an error.
                        sh0_d = bus.In;
                        sel_d = 2'd1;
                        err_d = (sel_p0 != 2'd0);
                    end else begin
                        unique case (sel_p0)
                            2'd0: begin
                                err_d   = 1'b1;
                                sel_d   = 2'd0;
                                state_d = HUNT;
                            end
                            2'd1: begin
                                sh1_d = bus.In;
                                sel_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d = bus.In;
                                sel_d = 2'd3;
                            end
                            2'd3: begin
                                out0_d = sh0_p0;
                                out1_d = sh1_p0;
                                out2_d = sh2_p0;
                                out3_d = bus.In;
                                vld_d  = 1'b1;
                                sel_d  = 2'd0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Stage p0: alignment state and slot shadows; stage p1: published frame.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state_p0 <= HUNT;
            sel_p0   <= 2'd0;
            sh0_p0   <= '0;
            sh1_p0   <= '0;
            sh2_p0   <= '0;
            out0_p1  <= '0;
            out1_p1  <= '0;
            out2_p1  <= '0;
            out3_p1  <= '0;
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state_p0 <= state_d;
            sel_p0   <= sel_d;
            sh0_p0   <= sh0_d;
            sh1_p0   <= sh1_d;
            sh2_p0   <= sh2_d;
            out0_p1  <= out0_d;
            out1_p1  <= out1_d;
            out2_p1  <= out2_d;
            out3_p1  <= out3_d;
            vld_p1   <= vld_d;
            err_p1   <= err_d;
        end
    end

    assign bus.Out0       = out0_p1;
    assign bus.Out1       = out1_p1;
    assign bus.Out2       = out2_p1;
    assign bus.Out3       = out3_p1;
    assign bus.Sel        = sel_p0;
    assign bus.Locked     = (state_p0 == LOCKED);
    assign bus.FrameValid = vld_p1;
    assign bus.SyncErr    = err_p1;
endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Scoreboard bench for tdm_demux_1_to_4 with WIDTH=4 and directed frames.
module tb_tdm_demux_1_to_4;
    localparam int W = 4;

    logic Clk = 1'b0;
    logic ResetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_fv = 0;

    typedef struct {
        bit         is_fv;
        logic [W-1:0] o0, o1, o2, o3;
        int         gap;
    } ev_t;

    ev_t exp_q[$];

    tdm_demux_1_to_4_if #(.WIDTH(W)) bus ();

    tdm_demux_1_to_4 #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .ResetN(ResetN),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit is_fv, input logic [W-1:0] a, b, c, d, input int gap);
        ev_t e;
        e.is_fv = is_fv;
        e.o0 = a; e.o1 = b; e.o2 = c; e.o3 = d;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] d, input logic fs);
        bus.InValid   = 1'b1;
        bus.In        = d;
        bus.FrameSync = fs;
        @(posedge Clk);
        #1;
        bus.InValid   = 1'b0;
        bus.FrameSync = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.InValid = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk_outs(input string name, input logic [W-1:0] a, b, c, d);
        chk({name, "_out"}, {bus.Out0, bus.Out1, bus.Out2, bus.Out3}, {a, b, c, d});
    endtask

    // Monitor: every FrameValid/SyncErr pulse must match the next expected event.
    always @(negedge Clk) begin
        if (ResetN && (bus.FrameValid || bus.SyncErr)) begin
            chk("fv_err_exclusive", {31'd0, bus.FrameValid && bus.SyncErr}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.FrameValid, bus.SyncErr}, 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, bus.FrameValid, bus.SyncErr},
                    e.is_fv ? 32'd2 : 32'd1);
                chk_outs(e.is_fv ? "frame" : "syncerr", e.o0, e.o1, e.o2, e.o3);
                if (e.is_fv && e.gap != 0) chk("fv_gap", cyc - last_fv, e.gap);
            end
            if (bus.FrameValid) last_fv = cyc;
        end
    end

    initial begin
        int t;
        bus.In = '0;
        bus.InValid = 1'b0;
        bus.FrameSync = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        ResetN = 1'b1;

        // reset values
        chk_outs("reset", 0, 0, 0, 0);
        chk("reset_sel", bus.Sel, 0);
        chk("reset_locked", bus.Locked, 0);

        // HUNT with no markers: nothing happens
        send(4'h3, 0); send(4'h5, 0); send(4'h7, 0);
        chk("hunt_locked", bus.Locked, 0);
        chk("hunt_sel", bus.Sel, 0);
        chk_outs("hunt", 0, 0, 0, 0);

        // back-to-back frames
        send(4'h1, 1);
        chk("lock_first", bus.Locked, 1);
        chk("sel_after_first", bus.Sel, 1);
        send(4'h2, 0); send(4'h3, 0);
        push(1, 4'h1, 4'h2, 4'h3, 4'h4, 0);
        send(4'h4, 0);
        chk("sel_wrap", bus.Sel, 0);
        send(4'h5, 1); send(4'h6, 0); send(4'h7, 0);
        push(1, 4'h5, 4'h6, 4'h7, 4'h8, 4);
        send(4'h8, 0);

        // idle gaps inside a frame
        idle(1);
        send(4'h9, 1);
        idle(2);
        chk("gap_sel_hold1", bus.Sel, 1);
        send(4'hA, 0);
        send(4'hB, 0);
        idle(3);
        chk("gap_sel_hold3", bus.Sel, 3);
        chk_outs("gap_hold", 4'h5, 4'h6, 4'h7, 4'h8);
        push(1, 4'h9, 4'hA, 4'hB, 4'hC, 0);
        send(4'hC, 0);

        // early marker on slot 2
        send(4'h7, 1); send(4'h8, 0);
        push(0, 4'h9, 4'hA, 4'hB, 4'hC, 0);
        send(4'hE, 1);
        chk("early_sel", bus.Sel, 1);
        chk("early_locked", bus.Locked, 1);
        send(4'hF, 0); send(4'h0, 0);
        push(1, 4'hE, 4'hF, 4'h0, 4'h1, 0);
        send(4'h1, 0);

        // missing marker on slot 0
        push(0, 4'hE, 4'hF, 4'h0, 4'h1, 0);
        send(4'h2, 0);
        chk("missing_locked", bus.Locked, 0);
        chk("missing_sel", bus.Sel, 0);
        send(4'h3, 0); send(4'h4, 0);
        chk("missing_still_hunt", bus.Locked, 0);
        send(4'h5, 1);
        chk("relock", bus.Locked, 1);
        send(4'h6, 0); send(4'h7, 0);
        push(1, 4'h5, 4'h6, 4'h7, 4'h8, 0);
        send(4'h8, 0);

        // reset mid-frame after slot 2
        send(4'h1, 1); send(4'h2, 0); send(4'h3, 0);
        ResetN = 1'b0;
        @(posedge Clk);
        #1;
        ResetN = 1'b1;
        chk_outs("midreset", 0, 0, 0, 0);
        chk("midreset_sel", bus.Sel, 0);
        chk("midreset_locked", bus.Locked, 0);
        send(4'h4, 0);
        chk("post_reset_hunt", bus.Locked, 0);
        idle(4);
        chk_outs("post_reset", 0, 0, 0, 0);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge Clk);
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdm_demux_1_to_4.md
Name: tdm_demux_1_to_4

Overview:
Receiving end of a 4-slot time-division-multiplexed link: one serial stream, one beat per slot, with a frame marker on slot 0. The block acquires frame alignment and steers each slot's beat to its channel. It presents all four channels together, once per complete frame, as registered outputs. It sits downstream of the 4:1 channel multiplexer on the same link and recovers In0..In3.

Parameters:
WIDTH, 1, data width of each slot beat and of each channel output.

Ports:
Clk  input  1  rising-edge clock
ResetN  input  1  synchronous active-low reset
In  input  WIDTH  TDM data beat
InValid  input  1  beat qualifier; In and FrameSync are sampled only when 1
FrameSync  input  1  marks the current beat as slot 0 of a frame
Out0  output  WIDTH  channel 0, registered
Out1  output  WIDTH  channel 1, registered
Out2  output  WIDTH  channel 2, registered
Out3  output  WIDTH  channel 3, registered
Sel  output  2  slot index expected for the next valid beat
Locked  output  1  frame alignment acquired
FrameValid  output  1  one-cycle pulse: Out0..Out3 updated this cycle
SyncErr  output  1  one-cycle pulse: frame marker violation detected

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-low (ResetN). It is sampled on the Clk rising edge only.
- Reset values: Out0..Out3=0, Sel=0, Locked=0, FrameValid=0, SyncErr=0. Shadow registers are cleared and the FSM enters HUNT.
- Reset mid-frame: the partial frame is discarded and no FrameValid is issued. Reset has priority over all other events.
- Cycles with InValid=0: no state change. Sel, the shadow registers and Out* hold. FrameValid and SyncErr are 0.
- FSM state HUNT (Locked=0):
  - Beats with FrameSync=0 are discarded.
  - A beat with FrameSync=1 is captured as slot 0. Next state is LOCKED, Sel becomes 1.
- FSM state LOCKED (Locked=1). Each valid beat is handled by the current value of Sel:
  - Sel=0, FrameSync=1: capture into shadow0; Sel becomes 1.
  - Sel=0, FrameSync=0: SyncErr pulses; the beat is discarded; go to HUNT with Sel=0.
  - Sel=1 or 2, FrameSync=0: capture into shadow1 or shadow2; Sel increments.
  - Sel=1, 2 or 3, FrameSync=1 (early marker): SyncErr pulses; the partial frame is discarded. The beat is captured as slot 0, Sel becomes 1, and the FSM stays LOCKED.
  - Sel=3, FrameSync=0: Out0..Out2 load from shadow0..2 and Out3 loads In, all on the same edge. FrameValid pulses in the cycle after that edge. Sel wraps to 0.
- Latency: Out* and FrameValid become valid on the first edge after the slot-3 beat is sampled, i.e. one cycle of latency.
- Out* hold their last complete frame until the next complete frame. A partial frame never changes Out*.
- Back-to-back frames with InValid held at 1 produce one FrameValid every 4 cycles.
- SyncErr and FrameValid are never asserted in the same cycle.
- With WIDTH>1, all data paths are WIDTH bits wide. There is no arithmetic on data; only the Sel counter wraps, modulo 4.

Test Plan:
1. Reset, then a continuous stream of A,B,C,D (FrameSync on A), WIDTH=4, values 1,2,3,4 → Locked=1 after the first beat. FrameValid pulses 1 cycle after beat D. Out0..3 read 1,2,3,4. Second frame 5,6,7,8 gives a pulse exactly 4 cycles later.
2. Stream with InValid gaps of 0–3 random idle cycles between beats of frame 9,A,B,C → the same single FrameValid after the last beat, with Out=9,A,B,C. Sel holds during the gaps.
3. Early marker: FrameSync asserted on the slot-2 beat (value E) → SyncErr=1 for one cycle, Out* unchanged, Sel=1. The next three beats F,0,1 complete the frame with Out=E,F,0,1.
4. Missing marker: a slot-0 beat arrives with FrameSync=0 → SyncErr pulses, Locked=0, and the beat is discarded. The following beats are ignored until FrameSync=1.
5. In HUNT, beats with FrameSync=0 only → no FrameValid, no SyncErr, Out* stay 0.
6. ResetN=0 for one cycle after slot 2 of a frame → all outputs return to reset values. The subsequent slot-3 beat is ignored (HUNT), and no FrameValid is issued.
